// File: rtl/sorted_bank_reader_pkg.sv
// sorted_bank_reader_pkg: shared types, widths and helpers for the sorted bank reader
//   BANK_ADDR_WIDTH row address width of each tuple bank; TUPLE_W width of one tuple_pair_t
package sorted_bank_reader_pkg;
  localparam int BANK_ADDR_WIDTH = 3;
  typedef struct packed {
    logic [15:0] key;
    logic [15:0] value;
  } tuple_pair_t;
  localparam int TUPLE_W = $bits(tuple_pair_t);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} reader_state_t;
  // Index of the final row, ceil(n/2)-1, computed one bit wider so n+1 cannot overflow.
  // The count is BANK_ADDR_WIDTH+1 bits, so it can never exceed the 2*2^BANK_ADDR_WIDTH
  // tuple capacity and needs no clamp.
  function automatic logic [BANK_ADDR_WIDTH-1:0] last_row_of(input logic [BANK_ADDR_WIDTH:0] n);
    logic [BANK_ADDR_WIDTH+1:0] rows;
    rows = ({1'b0, n} + (BANK_ADDR_WIDTH+2)'(1)) >> 1;
    return BANK_ADDR_WIDTH'(rows - (BANK_ADDR_WIDTH+2)'(1));
  endfunction
endpackage

// File: rtl/sorted_bank_reader_row_fifo.sv
// row_fifo: power-of-two deep row buffer between the bank read port and the tuple stream
//   clock/reset (async, active-high); push/din write a row; pop retires the head row;
//   dout is the head row; count is occupancy; empty flags count==0
module row_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  always_ff @(posedge clock) if (push) mem[wr] <= din;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign dout = mem[rd];
  assign empty = count == '0;
endmodule

// File: rtl/sorted_bank_reader.sv
// sorted_bank_reader: drains a sorted run from the even/odd tuple banks as a valid/ready tuple stream
//   clock, reset (async, active-high); start_in/count_in/pingpong_in launch a drain of N tuples;
//   bank_sel_out/read_addr_out/read_en_out drive the bank read port, even_data_in/odd_data_in return
//   one cycle later; tuple_out/valid_out/ready_in/last_out form the output stream;
//   busy_out is high while draining, done_out pulses once when the drain completes
module sorted_bank_reader
  import sorted_bank_reader_pkg::*;
#(
  parameter int ROW_FIFO_DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start_in,
  input  logic [BANK_ADDR_WIDTH:0]   count_in,
  input  logic                       pingpong_in,
  output logic                       bank_sel_out,
  output logic [BANK_ADDR_WIDTH-1:0] read_addr_out,
  output logic                       read_en_out,
  input  logic [TUPLE_W-1:0]         even_data_in,
  input  logic [TUPLE_W-1:0]         odd_data_in,
  output logic [TUPLE_W-1:0]         tuple_out,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic                       last_out,
  output logic                       busy_out,
  output logic                       done_out
);
  localparam int CW = $clog2(ROW_FIFO_DEPTH) + 1;
  reader_state_t state, next;
  logic [BANK_ADDR_WIDTH-1:0] row_addr, last_row;
  logic [BANK_ADDR_WIDTH:0] n, tuple_idx;
  logic inflight, empty, xfer, pop;
  logic [CW-1:0] fifo_count;
  logic [CW:0] occupancy;
  logic [2*TUPLE_W-1:0] head;
  row_fifo #(.DEPTH(ROW_FIFO_DEPTH), .WIDTH(2*TUPLE_W)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(inflight),
    .pop(pop),
    .din({even_data_in, odd_data_in}),
    .dout(head),
    .count(fifo_count),
    .empty(empty)
  );
  // A row already requested but not yet returned holds a reserved slot, so the push never overflows.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign read_en_out = state == RUN && occupancy < (CW+1)'(ROW_FIFO_DEPTH);
  assign read_addr_out = row_addr;
  assign valid_out = (state == RUN || state == DRAIN) && !empty;
  // Tuples leave in order, so the low bit of the tuple index picks the even or odd half of the head row.
  assign tuple_out = valid_out ? (tuple_idx[0] ? head[TUPLE_W-1:0] : head[2*TUPLE_W-1:TUPLE_W]) : '0;
  assign last_out = valid_out && tuple_idx == n - (BANK_ADDR_WIDTH+1)'(1);
  assign xfer = valid_out && ready_in;
  assign pop = xfer && (tuple_idx[0] || last_out);
  assign busy_out = state == RUN || state == DRAIN;
  assign done_out = state == DONE;
  always_comb begin
    next = state;
    unique case (state)
      IDLE:  next = start_in ? (count_in == '0 ? DONE : RUN) : IDLE;
      RUN:   next = (read_en_out && row_addr == last_row) ? DRAIN : RUN;
      DRAIN: next = (xfer && last_out) ? DONE : DRAIN;
      DONE:  next = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n <= '0;
      last_row <= '0;
      row_addr <= '0;
      tuple_idx <= '0;
      bank_sel_out <= 1'b0;
      inflight <= 1'b0;
    end else begin
      inflight <= read_en_out;
      if (state == IDLE && start_in) begin
        n <= count_in;
        last_row <= last_row_of(count_in);
        row_addr <= '0;
        tuple_idx <= '0;
        bank_sel_out <= pingpong_in;
      end
      if (read_en_out && row_addr != last_row) row_addr <= row_addr + 1'b1;
      if (xfer) tuple_idx <= tuple_idx + (BANK_ADDR_WIDTH+1)'(1);
    end
  end
endmodule

// File: tb/tb_sorted_bank_reader.sv
// tb_sorted_bank_reader: directed and randomized drains checked against a queue-based stream model
module tb_sorted_bank_reader;
  import sorted_bank_reader_pkg::*;
  localparam int AW = BANK_ADDR_WIDTH;
  localparam int TW = TUPLE_W;
  localparam int D = 2;
  localparam int ROWS = 1 << AW;
  logic clock = 0, reset = 1, start_in = 0, pingpong_in = 0, ready_in = 0;
  logic [AW:0] count_in = '0;
  logic bank_sel_out, read_en_out, valid_out, last_out, busy_out, done_out;
  logic [AW-1:0] read_addr_out;
  logic [TW-1:0] even_data_in = '0, odd_data_in = '0, tuple_out;
  logic [TW-1:0] bank_even [2][ROWS];
  logic [TW-1:0] bank_odd [2][ROWS];
  logic [TW-1:0] exp_q [$];
  int checks = 0, errors = 0;
  int n_cur, k, reads, popped, done_cnt, done_tick, first_valid, cyc;
  bit hold, sel_cur;

  sorted_bank_reader #(.ROW_FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .start_in(start_in), .count_in(count_in),
    .pingpong_in(pingpong_in), .bank_sel_out(bank_sel_out), .read_addr_out(read_addr_out),
    .read_en_out(read_en_out), .even_data_in(even_data_in), .odd_data_in(odd_data_in),
    .tuple_out(tuple_out), .valid_out(valid_out), .ready_in(ready_in), .last_out(last_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clock = ~clock;

  // Bank model: registered read, data valid exactly one cycle after the strobe.
  always @(posedge clock) begin
    if (read_en_out) begin
      even_data_in <= bank_even[bank_sel_out][read_addr_out];
      odd_data_in <= bank_odd[bank_sel_out][read_addr_out];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream-level model: tuples i=0..N-1 come from row i/2 in order; a row stays buffered until
  // its last needed tuple has been accepted, and at most D rows may be requested but unconsumed.
  task automatic monitor();
    if (read_en_out) begin
      chk("read_addr", read_addr_out, reads);
      chk("bank_sel", bank_sel_out, sel_cur);
      chk("read_room", (reads - popped) < D, 1);
      chk("read_bound", reads < (n_cur + 1) / 2, 1);
      reads++;
    end
    if (hold) chk("hold_valid", valid_out, 1);
    if (valid_out) begin
      if (first_valid < 0) first_valid = cyc;
      if (k < exp_q.size()) chk("tuple", tuple_out, exp_q[k]);
      else chk("extra_tuple", k, exp_q.size());
      chk("last", last_out, k == n_cur - 1);
      if (ready_in) begin
        if (k % 2 == 1 || k == n_cur - 1) popped++;
        k++;
        hold = 0;
      end else hold = 1;
    end else chk("last_idle", last_out, 0);
    if (done_out) begin
      done_cnt++;
      done_tick = cyc;
      chk("done_all", k, n_cur);
      chk("done_busy", busy_out, 0);
    end
  endtask

  task automatic tick(input logic rdy, input logic st);
    @(negedge clock);
    ready_in = rdy;
    start_in = st;
    cyc++;
    #1 monitor();
  endtask

  task automatic setup(input int n, input bit sel);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(i % 2 ? bank_odd[sel][i/2] : bank_even[sel][i/2]);
    n_cur = n;
    sel_cur = sel;
    k = 0;
    reads = 0;
    popped = 0;
    done_cnt = 0;
    done_tick = -1;
    first_valid = -1;
    hold = 0;
    cyc = -1;
    count_in = (AW+1)'(n);
    pingpong_in = sel;
  endtask

  // mode 0: ready held 1; 1: ready 1010.. with a 6-cycle stall; 2: random ready;
  // 3: ready held 1 with pingpong/count/start disturbed mid-run
  task automatic drain(input int n, input bit sel, input int mode);
    setup(n, sel);
    tick(1, 1);
    for (int c = 1; c < 300 && done_cnt == 0; c++) begin
      logic r;
      r = (mode == 0 || mode == 3) ? 1'b1 : mode == 1 ? ((c >= 12 && c < 18) ? 1'b0 : 1'(c % 2 == 0))
          : 1'($urandom_range(0, 3) != 0);
      if (mode == 3 && c == 4) begin
        pingpong_in = ~sel;
        count_in = 1;
      end
      tick(r, mode == 3 && c == 4);
    end
    chk("done_seen", done_cnt, 1);
    chk("tuple_count", k, n);
    chk("read_count", reads, (n + 1) / 2);
    if (mode == 0) begin
      chk("first_valid", first_valid, n > 0 ? 3 : -1);
      if (n > 0) chk("done_tick", done_tick, n + 3);
      else chk("done_tick_n0", done_tick >= 1 && done_tick <= 2, 1);
    end
    tick(1, 0);
    chk("done_once", done_cnt, 1);
    chk("idle_busy", busy_out, 0);
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) begin
      bank_even[0][r] = TW'(2*r + 1);
      bank_odd[0][r] = TW'(2*r + 2);
      bank_even[1][r] = TW'(32'h100 + 2*r + 1);
      bank_odd[1][r] = TW'(32'h100 + 2*r + 2);
    end
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_read_en", read_en_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_tuple", tuple_out, 0);
    chk("rst_addr", read_addr_out, 0);
    #11 reset = 0;
    drain(8, 0, 0);
    drain(5, 0, 0);
    drain(0, 0, 0);
    drain(8, 0, 1);
    drain(8, 0, 3);
    drain(8, 1, 0);
    setup(8, 0);
    tick(1, 1);
    for (int c = 0; c < 20 && k < 3; c++) tick(1, 0);
    chk("pre_reset_k", k, 3);
    #2 reset = 1;
    #1;
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_read_en", read_en_out, 0);
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_last", last_out, 0);
    chk("mid_rst_tuple", tuple_out, 0);
    chk("mid_rst_addr", read_addr_out, 0);
    chk("mid_rst_sel", bank_sel_out, 0);
    setup(0, 0);
    tick(1, 0);
    tick(1, 0);
    chk("no_done_on_reset", done_cnt, 0);
    reset = 0;
    drain(2, 1, 0);
    for (int r = 0; r < ROWS; r++) begin
      for (int s = 0; s < 2; s++) begin
        bank_even[s][r] = TW'($urandom);
        bank_odd[s][r] = TW'($urandom);
      end
    end
    for (int i = 0; i < 8; i++) drain(int'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 2);
    drain(15, 1, 1);
    drain(int'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
